// File: rtl/axi_rt_pkg.sv
// Shared definitions for the real-time transaction throttle: AXI channel
// structs, counter-width helper, stall-counter width and the limit clamp.
package axi_rt_pkg;

    localparam int unsigned StallCntWidth = 32'd32;
    localparam int unsigned AtopRResp     = 32'd5;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } axi_rt_aw_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } axi_rt_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_rt_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_rt_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_rt_r_t;

    typedef struct packed {
        axi_rt_aw_t aw;
        logic       aw_valid;
        axi_rt_w_t  w;
        logic       w_valid;
        logic       b_ready;
        axi_rt_ar_t ar;
        logic       ar_valid;
        logic       r_ready;
    } axi_rt_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      ar_ready;
        logic      w_ready;
        logic      b_valid;
        axi_rt_b_t b;
        logic      r_valid;
        axi_rt_r_t r;
    } axi_rt_resp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // The hardware cap always wins so the counters cannot run past it.
    function automatic logic [31:0] clamp_limit(input logic en, input logic [31:0] req,
                                                input logic [31:0] cap);
        logic [31:0] lim;
        if (en && (req < cap)) begin
            lim = req;
        end else begin
            lim = cap;
        end
        return lim;
    endfunction

endpackage

// File: rtl/axi_rt_txn_counter.sv
// One outstanding-transaction counter with its limit gate and the commit flag
// that keeps an already-presented request valid until it is accepted.
module axi_rt_txn_counter
    import axi_rt_pkg::*;
#(
    parameter int unsigned MaxTxns  = 32'd1,
    parameter int unsigned CntWidth = idx_width(MaxTxns + 32'd1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] max_i,
    input  logic                inc_a_i,
    input  logic                inc_b_i,
    input  logic                dec_i,
    input  logic                extra_block_i,
    input  logic                req_valid_i,
    input  logic                req_ready_i,
    output logic                at_limit_o,
    output logic                block_o,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth-1:0] cnt_d_s;
    logic                commit_r;
    logic                commit_d_s;
    logic [31:0]         lim_s;
    logic                fwd_valid_s;

    assign lim_s       = clamp_limit(enable_i, 32'(max_i), MaxTxns);
    assign at_limit_o  = (32'(cnt_r) >= lim_s);
    assign block_o     = (at_limit_o | extra_block_i) & ~commit_r;
    assign fwd_valid_s = req_valid_i & ~block_o;
    assign cnt_o       = cnt_r;

    // Net change of the outstanding count for this cycle's handshakes
    always_comb begin
        cnt_d_s = cnt_r + CntWidth'(inc_a_i) + CntWidth'(inc_b_i) - CntWidth'(dec_i);
    end

    // Remember a request shown downstream but not yet accepted
    always_comb begin
        if (fwd_valid_s && req_ready_i) begin
            commit_d_s = 1'b0;
        end else if (fwd_valid_s) begin
            commit_d_s = 1'b1;
        end else begin
            commit_d_s = commit_r;
        end
    end

    // Counter and commit flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r    <= {CntWidth{1'b0}};
            commit_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_d_s;
            commit_r <= commit_d_s;
        end
    end

endmodule

// File: rtl/axi_rt_txn_throttle.sv
// Outstanding-transaction limiter for the RT unit master port; all channels
// pass through combinationally. Optional stall statistics: AXI_RT_THROTTLE_STATS_EN.
module axi_rt_txn_throttle
    import axi_rt_pkg::*;
#(
    parameter int unsigned MaxReadTxns  = 32'd0,
    parameter int unsigned MaxWriteTxns = 32'd0,
    parameter type         axi_req_t    = axi_rt_req_t,
    parameter type         axi_resp_t   = axi_rt_resp_t,
    parameter int unsigned RCntWidth    = idx_width(MaxReadTxns + 32'd1),
    parameter int unsigned WCntWidth    = idx_width(MaxWriteTxns + 32'd1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  axi_req_t             slv_req_i,
    output axi_resp_t            slv_resp_o,
    output axi_req_t             mst_req_o,
    input  axi_resp_t            mst_resp_i,
    input  logic                 enable_i,
    input  logic [RCntWidth-1:0] max_r_i,
    input  logic [WCntWidth-1:0] max_w_i,
    output logic [RCntWidth-1:0] num_r_pending_o,
    output logic [WCntWidth-1:0] num_w_pending_o,
    output logic                 r_throttled_o,
`ifdef AXI_RT_THROTTLE_STATS_EN
    output logic                 w_throttled_o,
    input  logic                 clear_stats_i,
    output logic [31:0]          r_stall_o,
    output logic [31:0]          w_stall_o
`else
    output logic                 w_throttled_o
`endif
);

    logic r_block_s;
    logic w_block_s;
    logic r_at_limit_s;
    logic w_at_limit_s;
    logic atop_r_s;
    logic ar_hs_s;
    logic aw_hs_s;
    logic r_last_hs_s;
    logic b_hs_s;

    assign atop_r_s    = slv_req_i.aw.atop[AtopRResp];
    assign ar_hs_s     = slv_req_i.ar_valid & ~r_block_s & mst_resp_i.ar_ready;
    assign aw_hs_s     = slv_req_i.aw_valid & ~w_block_s & mst_resp_i.aw_ready;
    assign r_last_hs_s = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign b_hs_s      = mst_resp_i.b_valid & slv_req_i.b_ready;

    // Atomics with a read response also occupy a read slot.
    axi_rt_txn_counter #(
        .MaxTxns  (MaxReadTxns),
        .CntWidth (RCntWidth)
    ) u_r_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .max_i         (max_r_i),
        .inc_a_i       (ar_hs_s),
        .inc_b_i       (aw_hs_s & atop_r_s),
        .dec_i         (r_last_hs_s),
        .extra_block_i (1'b0),
        .req_valid_i   (slv_req_i.ar_valid),
        .req_ready_i   (mst_resp_i.ar_ready),
        .at_limit_o    (r_at_limit_s),
        .block_o       (r_block_s),
        .cnt_o         (num_r_pending_o)
    );

    axi_rt_txn_counter #(
        .MaxTxns  (MaxWriteTxns),
        .CntWidth (WCntWidth)
    ) u_w_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .max_i         (max_w_i),
        .inc_a_i       (aw_hs_s),
        .inc_b_i       (1'b0),
        .dec_i         (b_hs_s),
        .extra_block_i (atop_r_s & r_at_limit_s),
        .req_valid_i   (slv_req_i.aw_valid),
        .req_ready_i   (mst_resp_i.aw_ready),
        .at_limit_o    (w_at_limit_s),
        .block_o       (w_block_s),
        .cnt_o         (num_w_pending_o)
    );

    // Pass-through with only the AR/AW handshake gated
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~r_block_s;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~w_block_s;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~r_block_s;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_block_s;
    end

    assign r_throttled_o = r_block_s & slv_req_i.ar_valid;
    assign w_throttled_o = w_block_s & slv_req_i.aw_valid;

`ifdef AXI_RT_THROTTLE_STATS_EN
    logic [StallCntWidth-1:0] r_stall_r;
    logic [StallCntWidth-1:0] w_stall_r;

    // Saturating stall-cycle counters; a clear beats a same-cycle increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_r <= {StallCntWidth{1'b0}};
            w_stall_r <= {StallCntWidth{1'b0}};
        end else if (clear_stats_i) begin
            r_stall_r <= {StallCntWidth{1'b0}};
            w_stall_r <= {StallCntWidth{1'b0}};
        end else begin
            if (r_throttled_o && (r_stall_r != {StallCntWidth{1'b1}})) begin
                r_stall_r <= r_stall_r + 32'd1;
            end
            if (w_throttled_o && (w_stall_r != {StallCntWidth{1'b1}})) begin
                w_stall_r <= w_stall_r + 32'd1;
            end
        end
    end

    assign r_stall_o = r_stall_r;
    assign w_stall_o = w_stall_r;
`endif

endmodule

// File: tb/tb_axi_rt_txn_throttle.sv
// Bench for axi_rt_txn_throttle: directed vector table, commit/limit-lowering
// sequence, randomized traffic against a counting model, reset and statistics.
module tb_axi_rt_txn_throttle;
    import axi_rt_pkg::*;

    logic         clk;
    logic         rst;
    axi_rt_req_t  slv_req;
    axi_rt_resp_t slv_resp;
    axi_rt_req_t  mst_req;
    axi_rt_resp_t mst_resp;
    logic         enable;
    logic [2:0]   max_r;
    logic [2:0]   max_w;
    logic [2:0]   nr;
    logic [2:0]   nw;
    logic         r_thr;
    logic         w_thr;
`ifdef AXI_RT_THROTTLE_STATS_EN
    logic         clear_stats;
    logic [31:0]  r_stall;
    logic [31:0]  w_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    axi_rt_txn_throttle #(
        .MaxReadTxns  (32'd4),
        .MaxWriteTxns (32'd4),
        .axi_req_t    (axi_rt_req_t),
        .axi_resp_t   (axi_rt_resp_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .slv_req_i       (slv_req),
        .slv_resp_o      (slv_resp),
        .mst_req_o       (mst_req),
        .mst_resp_i      (mst_resp),
        .enable_i        (enable),
        .max_r_i         (max_r),
        .max_w_i         (max_w),
        .num_r_pending_o (nr),
        .num_w_pending_o (nw),
        .r_throttled_o   (r_thr),
`ifdef AXI_RT_THROTTLE_STATS_EN
        .w_throttled_o   (w_thr),
        .clear_stats_i   (clear_stats),
        .r_stall_o       (r_stall),
        .w_stall_o       (w_stall)
`else
        .w_throttled_o   (w_thr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] mr;
        logic [2:0] mw;
        logic       arv, arr, awv, awr, atop, rl, bh;
        logic [5:0] eo;   // {ar_valid, ar_ready, aw_valid, aw_ready, r_thr, w_thr}
        logic [2:0] enr;
        logic [2:0] enw;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [2:0] mr, input logic [2:0] mw,
                       input logic arv, input logic arr, input logic awv, input logic awr,
                       input logic atop, input logic rl, input logic bh,
                       input logic [5:0] eo, input logic [2:0] enr, input logic [2:0] enw);
        vec_t v;
        v.en = en; v.mr = mr; v.mw = mw; v.arv = arv; v.arr = arr; v.awv = awv;
        v.awr = awr; v.atop = atop; v.rl = rl; v.bh = bh; v.eo = eo; v.enr = enr; v.enw = enw;
        tbl.push_back(v);
    endtask

    task automatic set_in(input logic en, input logic [2:0] mr, input logic [2:0] mw,
                          input logic arv, input logic arr, input logic awv, input logic awr,
                          input logic atop, input logic rl, input logic bh);
        enable              = en;
        max_r               = mr;
        max_w               = mw;
        slv_req.ar_valid    = arv;
        mst_resp.ar_ready   = arr;
        slv_req.aw_valid    = awv;
        mst_resp.aw_ready   = awr;
        slv_req.aw.atop     = atop ? 6'b100000 : 6'b000000;
        mst_resp.r_valid    = rl;
        mst_resp.r.last     = 1'b1;
        slv_req.r_ready     = 1'b1;
        mst_resp.b_valid    = bh;
        slv_req.b_ready     = 1'b1;
    endtask

    function automatic logic [5:0] flags();
        return {mst_req.ar_valid, slv_resp.ar_ready, mst_req.aw_valid, slv_resp.aw_ready,
                r_thr, w_thr};
    endfunction

    function automatic int lim_of(input logic en, input logic [2:0] m);
        if (!en) return 4;
        return (int'(m) < 4) ? int'(m) : 4;
    endfunction

    initial begin
        int m_r, m_w;
        bit m_arp, m_awp, ar_hold, aw_hold;

        // Directed table: write limit 2 with held-off B
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011100, 3'd0, 3'd0);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011100, 3'd0, 3'd1);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b010001, 3'd0, 3'd2);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010001, 3'd0, 3'd2);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011100, 3'd0, 3'd1);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010000, 3'd0, 3'd2);
        add(1'b1, 3'd4, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'b010100, 3'd0, 3'd1);
        // ATOP with read response against a full read limit of 1
        add(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100, 3'd0, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000001, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b011100, 3'd0, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100, 3'd1, 3'd1);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000100, 3'd1, 3'd1);
        // Committed AR lands together with an R-last after the limit drops to 1
        add(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100, 3'd0, 3'd0);
        add(1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100100, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b110100, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000110, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000110, 3'd1, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100, 3'd0, 3'd0);
        add(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000100, 3'd1, 3'd0);
        // Limits disabled: hardware cap of 4 reads
        for (int k = 0; k < 4; k++)
            add(1'b0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110100, 3'(k), 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000110, 3'd4, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000110, 3'd4, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100, 3'd4, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000100, 3'd4, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100, 3'd3, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100, 3'd2, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b010100, 3'd1, 3'd0);
        add(1'b0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b010100, 3'd0, 3'd0);

        slv_req  = '0;
        mst_resp = '0;
        rst      = 1'b1;
`ifdef AXI_RT_THROTTLE_STATS_EN
        clear_stats = 1'b0;
`endif
        set_in(1'b1, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_nr", 32'(nr), 32'd0);
        check("rst_nw", 32'(nw), 32'd0);
        check("rst_thr", 32'({r_thr, w_thr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cnt", 32'({nr, nw}), 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            set_in(tbl[i].en, tbl[i].mr, tbl[i].mw, tbl[i].arv, tbl[i].arr, tbl[i].awv,
                   tbl[i].awr, tbl[i].atop, tbl[i].rl, tbl[i].bh);
            #1;
            check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tbl[i].eo));
            check($sformatf("vec%0d_cnt", i), 32'({nr, nw}), 32'({tbl[i].enr, tbl[i].enw}));
        end

        // Presented AR survives the limit dropping to 0, then new ARs block
        @(negedge clk);
        set_in(1'b1, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("cmt_first_valid", 32'({mst_req.ar_valid, slv_resp.ar_ready}), 32'b10);
        @(negedge clk);
        set_in(1'b1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("cmt_held_valid", 32'({mst_req.ar_valid, r_thr}), 32'b10);
        @(negedge clk);
        set_in(1'b1, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("cmt_handshake", 32'({mst_req.ar_valid, slv_resp.ar_ready}), 32'b11);
        @(negedge clk);
        #1;
        check("cmt_after_block", 32'({mst_req.ar_valid, r_thr, nr}), 32'b0_1_001);
        @(negedge clk);
        mst_resp.r_valid = 1'b1;
        #1;
        check("cmt_drain_block", 32'({mst_req.ar_valid, r_thr}), 32'b01);
        @(negedge clk);
        mst_resp.r_valid = 1'b0;
        #1;
        check("cmt_zero_limit", 32'({mst_req.ar_valid, r_thr, nr}), 32'b0_1_000);
        @(negedge clk);
        set_in(1'b1, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against a counting model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_r = 0; m_w = 0; m_arp = 1'b0; m_awp = 1'b0; ar_hold = 1'b0; aw_hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int lr, lw;
            bit atop_b, rb, wb, e_arv, e_arr, e_awv, e_awr, ar_acc, aw_acc, r_done, b_done;
            @(negedge clk);
            if ((c % 50) == 0) begin
                enable = ($urandom_range(3) != 0);
                max_r  = 3'($urandom_range(7));
                max_w  = 3'($urandom_range(7));
            end
            if (!ar_hold) begin
                slv_req.ar_valid = ($urandom_range(9) < 6);
                slv_req.ar.addr  = $urandom;
            end
            if (!aw_hold) begin
                slv_req.aw_valid = ($urandom_range(9) < 5);
                slv_req.aw.atop  = ($urandom_range(3) == 0) ? 6'b100000 : 6'b000000;
            end
            mst_resp.ar_ready = ($urandom_range(2) != 0);
            mst_resp.aw_ready = ($urandom_range(2) != 0);
            mst_resp.r_valid  = ($urandom_range(2) == 0);
            mst_resp.r.last   = (m_r > 0) && ($urandom_range(1) == 0);
            mst_resp.r.data   = $urandom;
            mst_resp.b_valid  = (m_w > 0) && ($urandom_range(2) == 0);
            #1;
            lr     = lim_of(enable, max_r);
            lw     = lim_of(enable, max_w);
            atop_b = slv_req.aw.atop[5];
            rb     = (m_r >= lr) && !m_arp;
            wb     = ((m_w >= lw) || (atop_b && (m_r >= lr))) && !m_awp;
            e_arv  = slv_req.ar_valid && !rb;
            e_arr  = mst_resp.ar_ready && !rb;
            e_awv  = slv_req.aw_valid && !wb;
            e_awr  = mst_resp.aw_ready && !wb;
            check($sformatf("rnd%0d_flags", c), 32'(flags()),
                  32'({e_arv, e_arr, e_awv, e_awr, rb && slv_req.ar_valid, wb && slv_req.aw_valid}));
            check($sformatf("rnd%0d_nr", c), 32'(nr), 32'(m_r));
            check($sformatf("rnd%0d_nw", c), 32'(nw), 32'(m_w));
            check($sformatf("rnd%0d_pass", c), mst_req.ar.addr ^ slv_resp.r.data,
                  slv_req.ar.addr ^ mst_resp.r.data);
            ar_acc = e_arv && mst_resp.ar_ready;
            aw_acc = e_awv && mst_resp.aw_ready;
            r_done = mst_resp.r_valid && mst_resp.r.last;
            b_done = mst_resp.b_valid;
            m_r = m_r + int'(ar_acc) + int'(aw_acc && atop_b) - int'(r_done);
            m_w = m_w + int'(aw_acc) - int'(b_done);
            if (e_arv) m_arp = !mst_resp.ar_ready;
            if (e_awv) m_awp = !mst_resp.aw_ready;
            ar_hold = slv_req.ar_valid && !ar_acc;
            aw_hold = slv_req.aw_valid && !aw_acc;
        end

        // Mid-operation reset clears the counters immediately
        @(negedge clk);
        set_in(1'b1, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        slv_req.ar_valid = 1'b0;
        #1;
        check("mid_pre_nr", 32'(nr), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cnt", 32'({nr, nw}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef AXI_RT_THROTTLE_STATS_EN
        check("stats_rst", r_stall, 32'd0);
        set_in(1'b1, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        slv_req.ar_valid = 1'b0;
        #1;
        check("stats_r10", r_stall, 32'd10);
        check("stats_w0", w_stall, 32'd0);
        @(negedge clk);
        slv_req.ar_valid = 1'b1;
        clear_stats      = 1'b1;
        @(negedge clk);
        clear_stats      = 1'b0;
        slv_req.ar_valid = 1'b0;
        #1;
        check("stats_clear", r_stall, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
